// File: rtl/sram_byte_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_byte_ctrl_pkg
// Purpose  : Shared types and constants for the word-to-byte SRAM controller.
//            state_t  - controller sequencing states
//            LANES    - byte lanes per bus word
//            LANE_W   - bits per byte lane
//            WORD_W   - bus word width
// Revision : 1.0 - initial release
// ============================================================================
package sram_byte_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int LANES  = 4;
   localparam int LANE_W = 8;
   localparam int WORD_W = LANES * LANE_W;

endpackage : sram_byte_ctrl_pkg
`default_nettype wire

// File: rtl/sram_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_byte_ctrl
// Purpose  : Splits one 32-bit bus access with per-byte write enables into
//            four sequential byte cycles on a single-port 8-bit synchronous
//            SRAM, reassembles the read bytes and answers with a one-cycle
//            ready pulse. Fixed 6-cycle access: IDLE, 4 lane cycles, DONE.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            bus_re     - word read request (level)
//            bus_we     - per-byte write enables, lane n = wdata[8n+7:8n]
//            bus_addr   - byte address, bits [1:0] ignored
//            bus_wdata  - write data, little-endian lanes
//            bus_ready  - one-cycle completion pulse
//            bus_rdata  - read data, held until the next completion
//            sram_re    - SRAM read enable
//            sram_we    - SRAM write enable
//            sram_addr  - SRAM byte address
//            sram_wdata - SRAM write byte
//            sram_rdata - SRAM read byte (combinational from the SRAM)
// Revision : 1.0 - initial release
// ============================================================================
module sram_byte_ctrl
   import sram_byte_ctrl_pkg::*;
#(
   parameter int alen = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bus_re,
   input  logic [LANES-1:0]    bus_we,
   input  logic [alen-1:0]     bus_addr,
   input  logic [WORD_W-1:0]   bus_wdata,
   output logic                bus_ready,
   output logic [WORD_W-1:0]   bus_rdata,
   output logic                sram_re,
   output logic                sram_we,
   output logic [alen-1:0]     sram_addr,
   output logic [LANE_W-1:0]   sram_wdata,
   input  logic [LANE_W-1:0]   sram_rdata
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t              state,      state_nxt;
   logic [1:0]          lane,       lane_nxt;
   logic [alen-3:0]     lat_base,   lat_base_nxt;
   logic                lat_re,     lat_re_nxt;
   logic [LANES-1:0]    lat_we,     lat_we_nxt;
   logic [WORD_W-1:0]   lat_wdata,  lat_wdata_nxt;
   logic [WORD_W-1:0]   cap_buf,    cap_buf_nxt;

   logic                ready_nxt;
   logic [WORD_W-1:0]   rdata_nxt;
   logic                sram_re_nxt;
   logic                sram_we_nxt;
   logic [alen-1:0]     sram_addr_nxt;
   logic [LANE_W-1:0]   sram_wdata_nxt;

   // Lane drive selection: the SRAM outputs are flops, so the command for a
   // lane is computed one cycle ahead. Lane 0 comes straight from the bus
   // inputs (the request is only being latched this same edge); later lanes
   // come from the latched copy.
   logic                drv_en;
   logic [1:0]          drv_lane;
   logic [alen-3:0]     drv_base;
   logic                drv_re;
   logic [LANES-1:0]    drv_we;
   logic [WORD_W-1:0]   drv_wdata;

   // Byte returned for the lane currently on the SRAM: the written byte for a
   // write lane, the SRAM output for a read lane, zero for an idle lane.
   logic [LANE_W-1:0]   cap_byte;

   // Word alignment drops the two low address bits.
   logic [1:0]          unused_addr_lsb;
   assign unused_addr_lsb = bus_addr[1:0];

   always_comb begin
      if (sram_we) begin
         cap_byte = sram_wdata;
      end else if (sram_re) begin
         cap_byte = sram_rdata;
      end else begin
         cap_byte = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      lane_nxt       = lane;
      lat_base_nxt   = lat_base;
      lat_re_nxt     = lat_re;
      lat_we_nxt     = lat_we;
      lat_wdata_nxt  = lat_wdata;
      cap_buf_nxt    = cap_buf;
      ready_nxt      = 1'b0;
      rdata_nxt      = bus_rdata;

      drv_en         = 1'b0;
      drv_lane       = 2'd0;
      drv_base       = lat_base;
      drv_re         = lat_re;
      drv_we         = lat_we;
      drv_wdata      = lat_wdata;

      unique case (state)
         IDLE: begin
            if (bus_re || (bus_we != '0)) begin
               lat_base_nxt  = bus_addr[alen-1:2];
               lat_re_nxt    = bus_re;
               lat_we_nxt    = bus_we;
               lat_wdata_nxt = bus_wdata;
               lane_nxt      = 2'd0;
               state_nxt     = XFER;
               drv_en        = 1'b1;
               drv_lane      = 2'd0;
               drv_base      = bus_addr[alen-1:2];
               drv_re        = bus_re;
               drv_we        = bus_we;
               drv_wdata     = bus_wdata;
            end
         end

         XFER: begin
            cap_buf_nxt[lane*LANE_W +: LANE_W] = cap_byte;
            if (lane == 2'd3) begin
               // Final lane byte goes straight into the response word.
               state_nxt = DONE;
               lane_nxt  = 2'd0;
               ready_nxt = 1'b1;
               rdata_nxt = {cap_byte, cap_buf[3*LANE_W-1:0]};
            end else begin
               lane_nxt  = lane + 2'd1;
               drv_en    = 1'b1;
               drv_lane  = lane + 2'd1;
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      sram_re_nxt    = 1'b0;
      sram_we_nxt    = 1'b0;
      sram_addr_nxt  = '0;
      sram_wdata_nxt = '0;
      if (drv_en) begin
         sram_addr_nxt = {drv_base, drv_lane};
         // Write wins over read on the same lane.
         if (drv_we[drv_lane]) begin
            sram_we_nxt    = 1'b1;
            sram_wdata_nxt = drv_wdata[drv_lane*LANE_W +: LANE_W];
         end else if (drv_re) begin
            sram_re_nxt    = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lane       <= 2'd0;
         lat_base   <= '0;
         lat_re     <= 1'b0;
         lat_we     <= '0;
         lat_wdata  <= '0;
         cap_buf    <= '0;
         bus_ready  <= 1'b0;
         bus_rdata  <= '0;
         sram_re    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         state      <= state_nxt;
         lane       <= lane_nxt;
         lat_base   <= lat_base_nxt;
         lat_re     <= lat_re_nxt;
         lat_we     <= lat_we_nxt;
         lat_wdata  <= lat_wdata_nxt;
         cap_buf    <= cap_buf_nxt;
         bus_ready  <= ready_nxt;
         bus_rdata  <= rdata_nxt;
         sram_re    <= sram_re_nxt;
         sram_we    <= sram_we_nxt;
         sram_addr  <= sram_addr_nxt;
         sram_wdata <= sram_wdata_nxt;
      end
   end

endmodule : sram_byte_ctrl
`default_nettype wire

// File: tb/tb_sram_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_byte_ctrl
// Purpose  : Self-checking bench for sram_byte_ctrl with a behavioural
//            byte-wide synchronous SRAM attached and a word-level reference
//            memory for expected read data and final memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_byte_ctrl;

   localparam int AL = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          bus_re;
   logic [3:0]    bus_we;
   logic [AL-1:0] bus_addr;
   logic [31:0]   bus_wdata;
   logic          bus_ready;
   logic [31:0]   bus_rdata;
   logic          sram_re;
   logic          sram_we;
   logic [AL-1:0] sram_addr;
   logic [7:0]    sram_wdata;
   logic [7:0]    sram_rdata;

   int            n_vec = 0;
   int            n_err = 0;
   logic          both_seen = 1'b0;
   logic          loading;

   logic [7:0]    mem     [256];
   logic [7:0]    ref_mem [256];

   always #5 clk = ~clk;

   sram_byte_ctrl #(.alen(AL)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_re     (bus_re),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_ready  (bus_ready),
      .bus_rdata  (bus_rdata),
      .sram_re    (sram_re),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   function automatic logic [7:0] init_pat(input int i);
      logic [31:0] v;
      v = i * 37 + 5;
      return v[7:0];
   endfunction

   // Behavioural synchronous SRAM; output is garbage unless a pure read.
   always @(posedge clk) begin
      if (loading) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_pat(i);
      end else if (sram_we) begin
         mem[sram_addr] <= sram_wdata;
      end
   end
   assign sram_rdata = (sram_re && !sram_we) ? mem[sram_addr] : 8'hC3;

   always @(negedge clk) if (sram_re && sram_we) both_seen = 1'b1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Word-level model: a written byte reads back as written, a read lane
   // returns memory, an untouched lane returns zero.
   function automatic logic [31:0] model_access(input logic re, input logic [3:0] we,
                                                input logic [7:0] addr, input logic [31:0] wd);
      logic [31:0] r;
      int          a;
      r = 32'h0;
      for (int n = 0; n < 4; n++) begin
         a = {addr[7:2], 2'b00} + n;
         if (we[n]) begin
            ref_mem[a]  = wd[8*n +: 8];
            r[8*n +: 8] = wd[8*n +: 8];
         end else if (re) begin
            r[8*n +: 8] = ref_mem[a];
         end
      end
      return r;
   endfunction

   // Caller is #1 after a rising edge with the DUT idle.
   task automatic do_access(input logic re, input logic [3:0] we,
                            input logic [7:0] addr, input logic [31:0] wd);
      logic [31:0] exp;
      logic [7:0]  base;
      exp  = model_access(re, we, addr, wd);
      base = {addr[7:2], 2'b00};
      bus_re = re; bus_we = we; bus_addr = addr; bus_wdata = wd;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         if (k <= 4) begin
            check_val($sformatf("we_l%0d", k-1), {31'h0, sram_we}, {31'h0, we[k-1]});
            check_val($sformatf("re_l%0d", k-1), {31'h0, sram_re}, {31'h0, re && !we[k-1]});
            check_val($sformatf("addr_l%0d", k-1), {24'h0, sram_addr}, {24'h0, base + 8'(k-1)});
            if (we[k-1]) check_val($sformatf("wdata_l%0d", k-1), {24'h0, sram_wdata}, {24'h0, wd[8*(k-1) +: 8]});
            check_val("rdy_early", {31'h0, bus_ready}, 32'h0);
         end else begin
            check_val("rdy", {31'h0, bus_ready}, 32'h1);
            check_val("rdata", bus_rdata, exp);
            check_val("done_en", {30'h0, sram_re, sram_we}, 32'h0);
            bus_re = 1'b0; bus_we = 4'h0;
         end
      end
      @(posedge clk); #1;
      check_val("rdy_after", {31'h0, bus_ready}, 32'h0);
      check_val("rdata_hold", bus_rdata, exp);
   endtask

   initial begin
      logic [31:0] exp;
      logic        re;
      logic [3:0]  we;
      rst = 1'b1; loading = 1'b1;
      bus_re = 1'b0; bus_we = 4'h0; bus_addr = '0; bus_wdata = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_pat(i);
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_outs", {bus_ready, sram_re, sram_we, sram_addr, sram_wdata},
                {1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
      check_val("rst_rdata", bus_rdata, 32'h0);
      rst = 1'b0; loading = 1'b0;
      @(posedge clk); #1;

      // Directed sequence
      do_access(1'b0, 4'hF, 8'h10, 32'hDEADBEEF);
      do_access(1'b1, 4'h0, 8'h10, 32'h0);
      do_access(1'b0, 4'b0100, 8'h10, 32'h00550000);
      do_access(1'b1, 4'h0, 8'h10, 32'h0);
      do_access(1'b1, 4'b0001, 8'h13, 32'h000000AA);
      check_val("mixed_ref", {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]}, 32'hDE55BEAA);

      // Reset while lane 2 is being set up: lanes 0 and 1 land, 2 and 3 do not.
      ref_mem[8'h20] = 8'h44;
      ref_mem[8'h21] = 8'h33;
      bus_re = 1'b0; bus_we = 4'hF; bus_addr = 8'h20; bus_wdata = 32'h11223344;
      @(posedge clk); #1;
      check_val("rst_l0_addr", {24'h0, sram_addr}, 32'h20);
      @(posedge clk); #1;
      check_val("rst_l1_addr", {24'h0, sram_addr}, 32'h21);
      rst = 1'b1; bus_we = 4'h0;
      @(posedge clk); #1;
      check_val("midrst_outs", {bus_ready, sram_re, sram_we, sram_addr, sram_wdata},
                {1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
      check_val("midrst_rdata", bus_rdata, 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check_val("midrst_noready", {31'h0, bus_ready}, 32'h0);
      end

      // Back-to-back reads held at 0x10
      exp = {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]};
      bus_re = 1'b1; bus_we = 4'h0; bus_addr = 8'h10;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #1;
         check_val($sformatf("b2b_rdy_c%0d", c), {31'h0, bus_ready},
                   {31'h0, (c == 5 || c == 11 || c == 17)});
         if (c == 5 || c == 11 || c == 17) check_val("b2b_rdata", bus_rdata, exp);
         if (c == 17) bus_re = 1'b0;
      end

      // Randomized accesses over a small window so they overlap
      for (int t = 0; t < 40; t++) begin
         re = 1'($urandom % 2);
         we = 4'($urandom % 16);
         if (!re && we == 4'h0) re = 1'b1;
         do_access(re, we, 8'($urandom_range(64, 127)), $urandom);
      end

      for (int i = 0; i < 256; i++) begin
         if (mem[i] !== ref_mem[i]) check_val($sformatf("mem_%02h", i), {24'h0, mem[i]}, {24'h0, ref_mem[i]});
      end
      check_val("mem_2223", {16'h0, mem[8'h23], mem[8'h22]}, {16'h0, init_pat(8'h23), init_pat(8'h22)});
      check_val("re_we_excl", {31'h0, both_seen}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sram_byte_ctrl
`default_nettype wire

// File: doc/sram_byte_ctrl.md
Name: sram_byte_ctrl

Overview:
- Bus-side controller placed directly upstream of the simulated 8-bit synchronous SRAM model in sim/dev.
- Converts one 32-bit word access with per-byte write enables into four sequential byte cycles on the SRAM's single-port re/we/addr/wdata/rdata interface.
- Reassembles read bytes and returns the result to the requester with a one-cycle ready pulse.
- Used by simulation top-levels to attach byte-wide SRAM models to the word-wide core memory bus.

Parameters:
- alen, 8: SRAM byte-address width; also the bus address width. Must be >= 3.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- bus_re  input  1  read request, level-sensitive.
- bus_we  input  4  per-byte write enables; lane n covers bus_wdata[8n+7:8n].
- bus_addr  input  alen  byte address; bits [1:0] are ignored (word-aligned).
- bus_wdata  input  32  write data, little-endian lanes.
- bus_ready  output  1  one-cycle pulse: access complete, bus_rdata valid.
- bus_rdata  output  32  read data; held until the next completion.
- sram_re  output  1  SRAM read enable.
- sram_we  output  1  SRAM write enable.
- sram_addr  output  alen  SRAM byte address.
- sram_wdata  output  8  SRAM write byte.
- sram_rdata  input  8  SRAM read byte; combinational, only meaningful while sram_re && !sram_we.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; lane counter 0; capture buffer 0.
- Reset mid-operation: the next cycle is IDLE with all outputs 0 and no bus_ready pulse. SRAM bytes already written remain written; nothing is rolled back.
- Registered outputs: every sram_* output and bus_ready/bus_rdata is a flop.
- States: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - Request = bus_re || (bus_we != 0).
  - On request: latch addr[alen-1:2], re, we and wdata; lane := 0; go to XFER. Otherwise stay.
- XFER, one cycle per lane, lane 0..3:
  - sram_addr = {latched_addr[alen-1:2], lane[1:0]}.
  - If we[lane]: sram_we=1, sram_re=0, sram_wdata = wdata byte. The SRAM writes at the end of the cycle.
  - Else if re: sram_re=1, sram_we=0. sram_rdata is captured into the buffer byte [lane] at the end of the cycle.
  - Else: sram_re=sram_we=0 (idle lane cycle, still consumed).
  - Write has precedence over read on the same lane. A written lane's buffer byte = the written wdata byte (read-after-write value).
  - Lanes neither read nor written: buffer byte = 0.
  - After lane 3: go to DONE.
- DONE:
  - bus_ready=1 for exactly one cycle; bus_rdata = buffer.
  - sram_re=sram_we=0; go to IDLE.
- Latency: request seen in IDLE at cycle 0; lanes in cycles 1-4; bus_ready in cycle 5. Fixed 6 cycles per access regardless of the enable mask.
- Handshake:
  - The requester holds the request stable until bus_ready.
  - Inputs in XFER/DONE are ignored.
  - A request still present in the cycle after bus_ready is treated as a new access. The requester deasserts or changes it on the edge ending the ready cycle.
- Back-to-back throughput: one access per 6 cycles.
- The controller never asserts sram_re and sram_we together. It never drives a read while the SRAM output is high-impedance and samples it.

Decomposition:
- Package sram_byte_ctrl_pkg:
  - state_t enum {IDLE, XFER, DONE}.
  - localparam LANES = 4.
  - localparam LANE_W = 8.
- No sub-module; the lane mux and capture logic stay inline.
- The bench instantiates this block together with the SRAM model.

Test Plan:
- Full write: we=4'hF, addr=0x10, wdata=0xDEADBEEF -> SRAM writes 0xEF@0x10, 0xBE@0x11, 0xAD@0x12, 0xDE@0x13 in cycles 1-4; bus_ready in cycle 5 only.
- Read: re=1, addr=0x10 -> sram_re high for cycles 1-4, sram_we never high; bus_rdata=0xDEADBEEF with the ready pulse.
- Partial write then read:
  - Write we=4'b0100, wdata=0x00550000 at 0x10 -> only 0x12 becomes 0x55.
  - Cycle 1 has no enables asserted.
  - Subsequent read returns 0xDE55BEEF.
- Mixed access: re=1, we=4'b0001, wdata=0x000000AA, addr=0x13 (low bits ignored) -> 0x10 written to 0xAA; bus_rdata=0xDE55BEAA.
- Reset during lane 2 of a full write of 0x11223344 to 0x20 -> 0x20=0x44 and 0x21=0x33 written, 0x22/0x23 unchanged; no bus_ready; all outputs 0 the cycle after reset.
- Back-to-back: reads held continuously at 0x10 -> bus_ready pulses at cycles 5, 11, 17; each pulse is exactly one cycle wide.
